// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10,
    PAR_RSVD = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    DONE,
    BRK_WAIT
  } rx_state_e;

  localparam int MIN_OVERSAMPLE = 8;

endpackage

// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - receive-side result bus of the UART
interface uart_rx_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_error;

  modport master (output rx_data, rx_valid, rx_error);
  modport slave  (input  rx_data, rx_valid, rx_error);
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional accumulator producing oversample ticks
module uart_baud_gen #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [39:0] inc,
  output logic        tick
);
  logic [39:0] acc_q;
  logic [39:0] sum;

  always_comb begin
    sum  = acc_q + inc;
    tick = en && !clr && (sum >= 40'(CLK_FREQ));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= tick ? (sum - 40'(CLK_FREQ)) : sum;
    end
  end
endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver with parity/framing checks
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] baud_rate,
  input  logic [1:0]  parity_mode,
  input  logic        stop_bits,
  input  logic        uart_rx,
  uart_rx_core_if.master rx_bus
);
  localparam int OS = (OVERSAMPLE < MIN_OVERSAMPLE) ? MIN_OVERSAMPLE : OVERSAMPLE;
  localparam int CW = $clog2(OS);
  localparam int IW = $clog2(DATA_WIDTH + 1);

  rx_state_e             state_q, state_d;
  logic [1:0]            sync_q;
  logic                  prev_q;
  logic [31:0]           baud_q;
  parity_e               par_q;
  logic                  stop2_q;
  logic [CW-1:0]         cnt_q;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  perr_q, ferr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, error_q;

  logic rx_s, fall, tick, mid_tick, par_en;
  logic [CW-1:0] mid_cnt;

  assign rx_s     = sync_q[1];
  assign fall     = prev_q & ~rx_s;
  assign par_en   = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
  // START waits half a bit so every later sample lands mid-bit
  assign mid_cnt  = (state_q == START) ? CW'(OS/2 - 1) : CW'(OS - 1);
  assign mid_tick = tick && (cnt_q == mid_cnt);

  uart_baud_gen #(.CLK_FREQ(CLK_FREQ)) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q != IDLE),
    .clr  (state_q == IDLE),
    .inc  (40'(baud_q) * 40'(OS)),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (fall && baud_rate != 32'd0) state_d = START;
      START:    if (mid_tick) state_d = rx_s ? IDLE : DATA;
      DATA:     if (mid_tick && idx_q == IW'(DATA_WIDTH - 1)) state_d = par_en ? PARITY : STOP1;
      PARITY:   if (mid_tick) state_d = STOP1;
      STOP1:    if (mid_tick) state_d = (stop2_q && rx_s) ? STOP2 : DONE;
      STOP2:    if (mid_tick) state_d = DONE;
      DONE:     state_d = ferr_q ? BRK_WAIT : IDLE;
      BRK_WAIT: if (rx_s) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      baud_q  <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], uart_rx};
      prev_q <= rx_s;
      if (state_q == IDLE) begin
        cnt_q  <= '0;
        idx_q  <= '0;
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
        if (fall && baud_rate != 32'd0) begin
          baud_q  <= baud_rate;
          par_q   <= parity_e'(parity_mode);
          stop2_q <= stop_bits;
        end
      end else if (tick) begin
        cnt_q <= mid_tick ? '0 : cnt_q + 1'b1;
      end
      if (mid_tick) begin
        case (state_q)
          DATA: begin
            shift_q <= {rx_s, shift_q[DATA_WIDTH-1:1]};
            idx_q   <= idx_q + 1'b1;
          end
          PARITY:       perr_q <= (^shift_q) ^ rx_s ^ (par_q == PAR_ODD);
          STOP1, STOP2: ferr_q <= ferr_q | ~rx_s;
          default: ;
        endcase
      end
      // Result is published on the same edge that enters DONE
      valid_q <= (state_d == DONE) && (state_q != DONE);
      if ((state_d == DONE) && (state_q != DONE)) begin
        data_q  <= shift_q;
        error_q <= perr_q | ferr_q | ~rx_s;
      end
    end
  end

  assign rx_bus.rx_data  = data_q;
  assign rx_bus.rx_valid = valid_q;
  assign rx_bus.rx_error = error_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed self-checking bench for uart_rx_core
module tb_uart_rx_core;
  localparam int BIT = 434;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] baud_rate;
  logic [1:0]  parity_mode;
  logic        stop_bits;
  logic        uart_rx;

  uart_rx_core_if #(.DATA_WIDTH(8)) bus ();

  uart_rx_core #(.DATA_WIDTH(8), .CLK_FREQ(50000000), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_rate  (baud_rate),
    .parity_mode(parity_mode),
    .stop_bits  (stop_bits),
    .uart_rx    (uart_rx),
    .rx_bus     (bus.slave)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = 0;
  logic [7:0] got_data;
  logic       got_err;
  logic [8:0] exp_q[$];
  logic [7:0] last_data = 8'h00;
  logic       prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: each pulse must match the oldest frame the stimulus declared complete
  always @(negedge clk) begin
    if (!rst_n) begin
      last_data = 8'h00;
      prev_valid = 1'b0;
    end else begin
      check("no_back_to_back_valid", {31'd0, prev_valid & bus.rx_valid}, 32'd0);
      if (bus.rx_valid) begin
        pulses++;
        pulse_cyc = cyc;
        got_data = bus.rx_data;
        got_err = bus.rx_error;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          check("pulse_data", {24'd0, bus.rx_data}, {24'd0, exp_q[0][7:0]});
          check("pulse_error", {31'd0, bus.rx_error}, {31'd0, exp_q[0][8]});
          last_data = exp_q[0][7:0];
          void'(exp_q.pop_front());
        end
      end else begin
        check("data_hold", {24'd0, bus.rx_data}, {24'd0, last_data});
      end
      prev_valid = bus.rx_valid;
    end
  end

  function automatic logic model_err(input logic [7:0] d, input logic [1:0] pm,
                                     input logic pbit, input logic stop_lvl);
    int ones;
    logic perr;
    ones = $countones(d) + int'(pbit);
    perr = 1'b0;
    if (pm == 2'b01) perr = (ones % 2) != 1;
    if (pm == 2'b10) perr = (ones % 2) != 0;
    return perr | ~stop_lvl;
  endfunction

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic idle_bits(input int n);
    uart_rx = 1'b1;
    repeat (n * BIT) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic sb,
                            input logic pbit, input logic stop_lvl, input int hold_low);
    parity_mode = pm;
    stop_bits = sb;
    exp_q.push_back({model_err(d, pm, pbit, stop_lvl), d});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pm == 2'b01 || pm == 2'b10) drive_bit(pbit);
    drive_bit(stop_lvl);
    if (sb) drive_bit(stop_lvl);
    for (int i = 0; i < hold_low; i++) drive_bit(1'b0);
    uart_rx = 1'b1;
  endtask

  initial begin
    int p0;
    int start_cyc;
    rst_n = 1'b0;
    uart_rx = 1'b1;
    baud_rate = 32'd115200;
    parity_mode = 2'b00;
    stop_bits = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_data", {24'd0, bus.rx_data}, 32'd0);
    check("reset_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("reset_error", {31'd0, bus.rx_error}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // 0xA5, no parity, one stop bit; pulse near 9.5 bit-times after start
    p0 = pulses;
    start_cyc = cyc;
    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 0);
    idle_bits(2);
    check("a5_count", pulses - p0, 32'd1);
    check("a5_data", {24'd0, got_data}, 32'h0000_00A5);
    check("a5_error", {31'd0, got_err}, 32'd0);
    check("a5_latency_ok", {31'd0, (pulse_cyc - start_cyc >= 4090) && (pulse_cyc - start_cyc <= 4170)}, 32'd1);

    // even parity, 0x3C has four ones
    send_frame(8'h3C, 2'b10, 1'b0, 1'b1, 1'b1, 0);
    idle_bits(2);
    check("even_bad_data", {24'd0, got_data}, 32'h0000_003C);
    check("even_bad_error", {31'd0, got_err}, 32'd1);
    send_frame(8'h3C, 2'b10, 1'b0, 1'b0, 1'b1, 0);
    idle_bits(2);
    check("even_good_error", {31'd0, got_err}, 32'd0);

    // odd parity, two stop bits, back-to-back
    p0 = pulses;
    send_frame(8'h00, 2'b01, 1'b1, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 2'b01, 1'b1, 1'b1, 1'b1, 0);
    idle_bits(2);
    check("b2b_count", pulses - p0, 32'd2);
    check("b2b_last_data", {24'd0, got_data}, 32'h0000_00FF);
    check("b2b_last_error", {31'd0, got_err}, 32'd0);

    // quarter-bit low glitch is a false start
    p0 = pulses;
    uart_rx = 1'b0;
    repeat (BIT / 4) @(posedge clk);
    idle_bits(2);
    check("glitch_no_pulse", pulses - p0, 32'd0);
    send_frame(8'h12, 2'b00, 1'b0, 1'b0, 1'b1, 0);
    idle_bits(2);
    check("post_glitch_data", {24'd0, got_data}, 32'h0000_0012);

    // framing error followed by a long break yields one errored frame
    p0 = pulses;
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 20);
    idle_bits(2);
    check("break_count", pulses - p0, 32'd1);
    check("break_data", {24'd0, got_data}, 32'h0000_0055);
    check("break_error", {31'd0, got_err}, 32'd1);
    send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 0);
    idle_bits(2);
    check("post_break_count", pulses - p0, 32'd2);
    check("post_break_data", {24'd0, got_data}, 32'h0000_0081);
    check("post_break_error", {31'd0, got_err}, 32'd0);

    // reset in the middle of 0xF0's data bits
    p0 = pulses;
    parity_mode = 2'b00;
    stop_bits = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    uart_rx = 1'b0;
    repeat (BIT / 2) @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_data", {24'd0, bus.rx_data}, 32'd0);
    check("midreset_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("midreset_error", {31'd0, bus.rx_error}, 32'd0);
    uart_rx = 1'b1;
    repeat (10) @(posedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    check("midreset_no_pulse", pulses - p0, 32'd0);
    send_frame(8'h0F, 2'b00, 1'b0, 1'b0, 1'b1, 0);
    idle_bits(2);
    check("post_reset_data", {24'd0, got_data}, 32'h0000_000F);
    check("post_reset_error", {31'd0, got_err}, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
